led_arbiter: RTL and testbench

Shares the board's 8-bit LED bank between up to four on-chip requesters (processor debug port, status monitors, etc.) and falls back to mirroring the slide switches when no one requests it. It sits between the core logic and the top-level `led` pins, replacing the direct switch-to-LED connection. A round-robin arbiter with a minimum dwell time keeps each owner's pattern visible long enough to read.

---
 rtl/led_arbiter.sv | 173 +++++++++++++++++
 tb/tb_led_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/led_arbiter.sv
// led_arbiter
//   Shares the 8-bit LED bank between up to four requesters using a
//   round-robin arbiter with a minimum dwell time. When nobody owns the
//   LEDs they mirror the (synchronized, optionally debounced) slide switches.
//
//   Optional feature macro: LED_ARB_DEBOUNCE_EN
//     defined   -> switch value must be stable DEB_CYCLES cycles before use
//     undefined -> synchronized switches drive the LEDs directly
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous reset, active-high
//   req        in   4   per-requester LED request
//   req_data   in  32   packed patterns, byte i belongs to requester i
//   sw         in   8   raw slide switches (asynchronous)
//   gnt        out  4   one-hot grant, zero when idle
//   active_id  out  2   index of current owner (valid while gnt != 0)
//   led        out  8   registered LED drive
//
// State   | meaning
// --------+-----------------------------------------------
// S_IDLE  | no owner, LEDs mirror the clean switch value
// S_OWN   | one requester owns the LEDs, dwell counting down

module led_arbiter #(
  parameter int HOLD_CYCLES = 1000000,
  parameter int DEB_CYCLES  = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  input  logic [7:0]  sw,
  output logic [3:0]  gnt,
  output logic [1:0]  active_id,
  output logic [7:0]  led
);

  localparam int DW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_INIT = DW'(HOLD_CYCLES - 1);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t        r_state;
  logic [3:0]    r_gnt;
  logic [1:0]    r_active_id;
  logic [7:0]    r_led;
  logic [1:0]    r_ptr;
  logic [DW-1:0] r_dwell;

  logic [7:0]    r_sw_meta;
  logic [7:0]    r_sw_sync;
  logic [7:0]    w_sw_clean;

  logic [1:0]    w_winner;
  logic          w_found;
  logic          w_others;
  logic          w_own_req;
  logic [7:0]    w_own_data;

  // Two-flop synchronizer for the asynchronous switches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
    end
  end

`ifdef LED_ARB_DEBOUNCE_EN
  localparam int DBW = $clog2(DEB_CYCLES + 1);
  localparam logic [DBW-1:0] DEB_INIT = DBW'(DEB_CYCLES - 1);

  logic [7:0]     r_sw_cand;
  logic [7:0]     r_sw_clean;
  logic [DBW-1:0] r_deb_cnt;

  // Any change in the synchronized value reloads the counter; the candidate
  // is accepted only once the counter has run down without interruption.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_cand  <= '0;
      r_sw_clean <= '0;
      r_deb_cnt  <= '0;
    end else if (r_sw_sync != r_sw_cand) begin
      r_sw_cand <= r_sw_sync;
      r_deb_cnt <= DEB_INIT;
    end else if (r_deb_cnt != '0) begin
      r_deb_cnt <= r_deb_cnt - DBW'(1);
    end else begin
      r_sw_clean <= r_sw_cand;
    end
  end

  assign w_sw_clean = r_sw_clean;
`else
  logic w_unused_deb;
  assign w_unused_deb = (DEB_CYCLES > 0);
  assign w_sw_clean   = r_sw_sync;
`endif

  // Round-robin search: ptr+1, ptr+2, ptr+3, ptr. Since ptr tracks the
  // current owner, the owner is naturally considered last.
  always_comb begin
    w_winner = r_ptr;
    w_found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] idx;
      idx = r_ptr + 2'(k);
      if (!w_found && req[idx]) begin
        w_winner = idx;
        w_found  = 1'b1;
      end
    end
  end

  assign w_others   = |(req & ~r_gnt);
  assign w_own_req  = req[r_active_id];
  assign w_own_data = req_data[{r_active_id, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_active_id <= '0;
      r_led       <= '0;
      r_ptr       <= 2'd3;
      r_dwell     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_led <= w_sw_clean;
          if (w_found) begin
            r_state     <= S_OWN;
            r_gnt       <= 4'b0001 << w_winner;
            r_active_id <= w_winner;
            r_ptr       <= w_winner;
            r_dwell     <= DWELL_INIT;
          end
        end
        S_OWN: begin
          // Owner's pattern tracks while it requests, otherwise frozen.
          if (w_own_req) begin
            r_led <= w_own_data;
          end
          if (r_dwell != '0) begin
            r_dwell <= r_dwell - DW'(1);
          end else if (w_others) begin
            // Direct hand-over, no idle bubble.
            r_gnt       <= 4'b0001 << w_winner;
            r_active_id <= w_winner;
            r_ptr       <= w_winner;
            r_dwell     <= DWELL_INIT;
          end else if (!w_own_req) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign active_id = r_active_id;
  assign led       = r_led;

endmodule

// File: tb/tb_led_arbiter.sv
// Testbench for led_arbiter. Three instances with different dwell lengths
// share one stimulus stream; expectations are queued before each clock edge
// and compared right after it.

module tb_led_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [7:0]  sw;

  logic [3:0]  gnt_u [3];
  logic [1:0]  id_u  [3];
  logic [7:0]  led_u [3];

  int errors = 0;
  int checks = 0;
  bit nodeb;

  typedef struct {
    string      tag;
    int         unit;
    logic [3:0] gnt;
    logic [1:0] id;
    bit         chk_id;
    logic [7:0] led;
    bit         chk_led;
  } exp_t;

  exp_t sb[$];

  logic [7:0] rr_led [9] = '{8'h00, 8'h11, 8'h11, 8'h22, 8'h22,
                             8'h33, 8'h33, 8'h44, 8'h44};

  led_arbiter #(.HOLD_CYCLES(4), .DEB_CYCLES(8)) u_h4 (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .sw(sw),
    .gnt(gnt_u[0]), .active_id(id_u[0]), .led(led_u[0]));

  led_arbiter #(.HOLD_CYCLES(2), .DEB_CYCLES(8)) u_h2 (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .sw(sw),
    .gnt(gnt_u[1]), .active_id(id_u[1]), .led(led_u[1]));

  led_arbiter #(.HOLD_CYCLES(5), .DEB_CYCLES(8)) u_h5 (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .sw(sw),
    .gnt(gnt_u[2]), .active_id(id_u[2]), .led(led_u[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_out(input string tag, input int unit,
                            input logic [3:0] g, input logic [1:0] id,
                            input bit chk_id, input logic [7:0] l,
                            input bit chk_led);
    exp_t e;
    e.tag = tag; e.unit = unit; e.gnt = g; e.id = id;
    e.chk_id = chk_id; e.led = l; e.chk_led = chk_led;
    sb.push_back(e);
  endtask

  // Advance one edge, then compare every expectation queued for it.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (gnt_u[e.unit] === e.gnt) else begin
        errors++;
        $error("FAIL %s gnt[u%0d]: observed=%b expected=%b",
               e.tag, e.unit, gnt_u[e.unit], e.gnt);
      end
      if (e.chk_id) begin
        checks++;
        assert (id_u[e.unit] === e.id) else begin
          errors++;
          $error("FAIL %s active_id[u%0d]: observed=%0d expected=%0d",
                 e.tag, e.unit, id_u[e.unit], e.id);
        end
      end
      if (e.chk_led) begin
        checks++;
        assert (led_u[e.unit] === e.led) else begin
          errors++;
          $error("FAIL %s led[u%0d]: observed=%h expected=%h",
                 e.tag, e.unit, led_u[e.unit], e.led);
        end
      end
    end
  endtask

  initial begin
`ifdef LED_ARB_DEBOUNCE_EN
    nodeb = 1'b0;
`else
    nodeb = 1'b1;
`endif
    rst = 1'b1; req = 4'b0000; req_data = 32'h0; sw = 8'hA5;

    // Reset and idle mirror
    for (int c = 0; c < 2; c++) begin
      for (int u = 0; u < 3; u++) expect_out("reset", u, 4'b0000, 2'd0, 1'b1, 8'h00, 1'b1);
      step();
    end
    rst = 1'b0;
    expect_out("mirror_e1", 0, 4'b0000, 2'd0, 1'b0, 8'h00, 1'b1); step();
    expect_out("mirror_e2", 0, 4'b0000, 2'd0, 1'b0, 8'h00, 1'b1); step();
    expect_out("mirror_e3", 0, 4'b0000, 2'd0, 1'b0, 8'hA5, nodeb); step();

    // Single request, HOLD=4
    req = 4'b0100; req_data = 32'h003C_0000;
    expect_out("single_grant", 0, 4'b0100, 2'd2, 1'b1, 8'hA5, nodeb); step();
    expect_out("single_data", 0, 4'b0100, 2'd2, 1'b1, 8'h3C, 1'b1); step();
    req = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      expect_out("single_hold", 0, 4'b0100, 2'd2, 1'b1, 8'h3C, 1'b1); step();
    end
    expect_out("single_release", 0, 4'b0000, 2'd0, 1'b0, 8'h3C, 1'b1); step();
    expect_out("single_back_sw", 0, 4'b0000, 2'd0, 1'b0, 8'hA5, nodeb); step();
    repeat (4) step();

    // Round-robin fairness, HOLD=2
    rst = 1'b1;
    expect_out("rr_reset", 1, 4'b0000, 2'd0, 1'b1, 8'h00, 1'b1); step();
    rst = 1'b0; req = 4'b1111; req_data = 32'h4433_2211;
    for (int k = 0; k < 9; k++) begin
      logic [1:0] rid;
      rid = 2'((k / 2) % 4);
      expect_out("rr_cycle", 1, 4'b0001 << rid, rid, 1'b1, rr_led[k], 1'b1);
      step();
    end
    req = 4'b0000;
    repeat (8) step();

    // Early drop, HOLD=5
    rst = 1'b1; step();
    rst = 1'b0; req = 4'b0010; req_data = 32'h0000_5A00;
    expect_out("drop_grant", 2, 4'b0010, 2'd1, 1'b1, 8'h00, 1'b1); step();
    expect_out("drop_data", 2, 4'b0010, 2'd1, 1'b1, 8'h5A, 1'b1); step();
    req = 4'b0000; req_data = 32'h0000_FF00;
    for (int c = 0; c < 3; c++) begin
      expect_out("drop_frozen", 2, 4'b0010, 2'd1, 1'b1, 8'h5A, 1'b1); step();
    end
    expect_out("drop_release", 2, 4'b0000, 2'd0, 1'b0, 8'h5A, 1'b1); step();
    repeat (6) step();

    // Reset mid-grant, HOLD=4 (ptr is 1 here, so requester 3 is found)
    req = 4'b1000; req_data = 32'hC300_0000;
    expect_out("mid_grant", 0, 4'b1000, 2'd3, 1'b1, 8'hA5, nodeb); step();
    expect_out("mid_data", 0, 4'b1000, 2'd3, 1'b1, 8'hC3, 1'b1); step();
    rst = 1'b1;
    expect_out("mid_reset", 0, 4'b0000, 2'd0, 1'b1, 8'h00, 1'b1);
    expect_out("mid_reset", 1, 4'b0000, 2'd0, 1'b1, 8'h00, 1'b1);
    step();
    checks++;
    assert (u_h4.r_ptr === 2'd3) else begin
      errors++;
      $error("FAIL mid_reset_ptr: observed=%0d expected=3", u_h4.r_ptr);
    end
    rst = 1'b0;
    expect_out("mid_regrant", 0, 4'b1000, 2'd3, 1'b1, 8'h00, 1'b1); step();

`ifdef LED_ARB_DEBOUNCE_EN
    req = 4'b0000; sw = 8'h00;
    repeat (19) step();
    expect_out("deb_base", 0, 4'b0000, 2'd0, 1'b0, 8'h00, 1'b1); step();
    sw = 8'h01;
    repeat (5) step();
    sw = 8'h00;
    repeat (14) step();
    expect_out("deb_glitch", 0, 4'b0000, 2'd0, 1'b0, 8'h00, 1'b1); step();
    sw = 8'h01;
    repeat (14) step();
    expect_out("deb_accept", 0, 4'b0000, 2'd0, 1'b0, 8'h01, 1'b1); step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
